ss_dfifo: RTL



---
 rtl/ss_dfifo.sv | 78 +++++++
 1 files changed

// File: rtl/ss_dfifo.sv
// ss_dfifo: FWFT 64-bit beat FIFO between the source and destination scatter-gather engines,
// deriving each engine's start/stop/end flow controls from occupancy, end-of-chain and abort.
module ss_dfifo #(
  parameter int AW    = 4,
  parameter int BURST = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [63:0]   src_dat,
  input  logic          src_xfer,
  input  logic          src_last,
  output logic          src_start,
  output logic          src_stop,
  output logic          src_end,
  output logic [63:0]   dst_dat,
  input  logic          dst_xfer,
  input  logic          dst_last,
  output logic          dst_start,
  output logic          dst_stop,
  output logic          dst_end,
  input  logic          job_done,
  input  logic          abort,
  output logic [AW:0]   level,
  output logic [2:0]    err
);
  localparam int         DEPTH  = 1 << AW;
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_NEARF = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] L_BURST = (AW+1)'(BURST);
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_eof, r_abt;
  logic [2:0]    r_err;
  logic          w_full, w_empty, w_wr, w_rd, w_ovf, w_unf, w_short;
  assign w_full  = r_count == L_DEPTH;
  assign w_empty = r_count == '0;
  // Writes are refused once aborted; reads keep draining
  assign w_wr    = src_xfer & ~src_last & ~r_abt & ~w_full;
  assign w_ovf   = src_xfer & ~src_last & ~r_abt & w_full;
  assign w_rd    = dst_xfer & ~dst_last & ~w_empty;
  assign w_unf   = dst_xfer & ~dst_last & w_empty;
  assign w_short = dst_xfer & dst_last & (~w_empty | ~r_eof);
  always_ff @(posedge wb_clk_i)
    if (w_wr) r_mem[r_wr_ptr] <= src_dat;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_eof    <= 1'b0;
      r_abt    <= 1'b0;
      r_err    <= '0;
    end else if (job_done) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_eof    <= 1'b0;
      r_abt    <= 1'b0;
      r_err    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      if (src_xfer & src_last) r_eof <= 1'b1;
      if (abort) r_abt <= 1'b1;
      r_err <= r_err | {w_short, w_unf, w_ovf};
    end
  assign dst_dat   = r_mem[r_rd_ptr];
  assign level     = r_count;
  assign err       = r_err;
  assign src_start = (L_DEPTH - r_count >= L_BURST) & ~r_eof & ~r_abt;
  assign src_stop  = (r_count >= L_NEARF) | r_abt;
  assign src_end   = r_abt;
  assign dst_start = ((r_count >= L_BURST) | (r_eof & ~w_empty)) & ~r_abt;
  assign dst_stop  = (r_count <= (AW+1)'(1)) | r_abt;
  assign dst_end   = r_abt | (r_eof & w_empty) | r_err[2];
endmodule
